// File: rtl/rf80386_pkg.sv
// Shared types for the transaction tracker: per-slot state encoding,
// completion status codes and a backoff helper.
package rf80386_pkg;

    typedef enum logic [2:0] {
        SLOT_FREE  = 3'd0,
        SLOT_PEND  = 3'd1,
        SLOT_RWAIT = 3'd2,
        SLOT_RRDY  = 3'd3,
        SLOT_DONE  = 3'd4
    } slot_state_e;

    typedef enum logic [1:0] {
        DST_ACK  = 2'd0,
        DST_ERR  = 2'd1,
        DST_TMO  = 2'd2,
        DST_RTYX = 2'd3
    } done_st_e;

    // Double the backoff, saturating at the ceiling.
    function automatic int unsigned sat_dbl(input int unsigned b, input int unsigned m);
        return ((b << 1) > m) ? m : (b << 1);
    endfunction

endpackage

// File: rtl/fta_tran_tracker_if.sv
// Allocation, response, retry and completion channels of the tracker.
interface fta_tran_tracker_if #(
    parameter int TIDW = 4
);
    logic            alloc_req_i;
    logic            alloc_gnt_o;
    logic [TIDW-1:0] alloc_tid_o;
    logic            resp_v_i;
    logic [TIDW-1:0] resp_tid_i;
    logic            resp_ack_i;
    logic            resp_rty_i;
    logic            resp_err_i;
    logic            retry_v_o;
    logic [TIDW-1:0] retry_tid_o;
    logic            retry_take_i;
    logic            done_v_o;
    logic [TIDW-1:0] done_tid_o;
    logic [1:0]      done_st_o;

    modport slave (
        input  alloc_req_i, resp_v_i, resp_tid_i, resp_ack_i, resp_rty_i, resp_err_i, retry_take_i,
        output alloc_gnt_o, alloc_tid_o, retry_v_o, retry_tid_o, done_v_o, done_tid_o, done_st_o
    );

    modport master (
        output alloc_req_i, resp_v_i, resp_tid_i, resp_ack_i, resp_rty_i, resp_err_i, retry_take_i,
        input  alloc_gnt_o, alloc_tid_o, retry_v_o, retry_tid_o, done_v_o, done_tid_o, done_st_o
    );
endinterface

// File: rtl/fta_tran_slot.sv
// One outstanding-transaction slot: lifecycle FSM, response timer (reused
// as the backoff counter while waiting to retry), backoff and retry count.
module fta_tran_slot
    import rf80386_pkg::*;
#(
    parameter int TIDW      = 4,
    parameter int TMO       = 255,
    parameter int RTY_BASE  = 4,
    parameter int RTY_MAX   = 64,
    parameter int RTY_LIMIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            grant_i,
    input  logic [TIDW-1:0] tid_i,
    input  logic            resp_v_i,
    input  logic [TIDW-1:0] resp_tid_i,
    input  logic            resp_ack_i,
    input  logic            resp_rty_i,
    input  logic            resp_err_i,
    input  logic            retry_take_i,
    input  logic            done_take_i,
    output slot_state_e     state_o,
    output logic [TIDW-1:0] tid_o,
    output logic [1:0]      st_o,
    output logic            hit_o
);
    localparam int TMAX = (TMO > RTY_MAX) ? TMO : RTY_MAX;
    localparam int TMRW = $clog2(TMAX + 1);
    localparam int BKW  = $clog2(RTY_MAX + 1);
    localparam int RCW  = $clog2(RTY_LIMIT + 1);

    slot_state_e     state_q, state_d;
    logic [TIDW-1:0] tid_q, tid_d;
    done_st_e        st_q, st_d;
    logic [TMRW-1:0] tmr_q, tmr_d, tmr_inc_s;
    logic [BKW-1:0]  bko_q, bko_d;
    logic [RCW-1:0]  rcnt_q, rcnt_d;
    logic            hit_s;

    assign hit_s     = resp_v_i && (state_q == SLOT_PEND) && (resp_tid_i == tid_q);
    assign tmr_inc_s = tmr_q + TMRW'(1);

    // Next-state: flush dominates; within PEND a response beats the timeout.
    always_comb begin
        state_d = state_q;
        tid_d   = tid_q;
        st_d    = st_q;
        tmr_d   = tmr_q;
        bko_d   = bko_q;
        rcnt_d  = rcnt_q;
        if (flush_i) begin
            state_d = SLOT_FREE;
        end else begin
            case (state_q)
                SLOT_FREE: begin
                    if (grant_i) begin
                        state_d = SLOT_PEND;
                        tid_d   = tid_i;
                        tmr_d   = '0;
                        rcnt_d  = '0;
                        bko_d   = BKW'(RTY_BASE);
                    end else begin
                        state_d = SLOT_FREE;
                    end
                end
                SLOT_PEND: begin
                    if (hit_s && resp_err_i) begin
                        state_d = SLOT_DONE;
                        st_d    = DST_ERR;
                    end else if (hit_s && resp_rty_i) begin
                        if (rcnt_q == RCW'(RTY_LIMIT)) begin
                            state_d = SLOT_DONE;
                            st_d    = DST_RTYX;
                        end else begin
                            state_d = SLOT_RWAIT;
                            rcnt_d  = rcnt_q + RCW'(1);
                            tmr_d   = '0;
                        end
                    end else if (hit_s && resp_ack_i) begin
                        state_d = SLOT_DONE;
                        st_d    = DST_ACK;
                    end else if (tmr_inc_s == TMRW'(TMO)) begin
                        state_d = SLOT_DONE;
                        st_d    = DST_TMO;
                    end else begin
                        tmr_d = tmr_inc_s;
                    end
                end
                SLOT_RWAIT: begin
                    if (tmr_inc_s == TMRW'(bko_q)) begin
                        state_d = SLOT_RRDY;
                        bko_d   = BKW'(sat_dbl(32'(bko_q), unsigned'(RTY_MAX)));
                    end else begin
                        tmr_d = tmr_inc_s;
                    end
                end
                SLOT_RRDY: begin
                    if (retry_take_i) begin
                        state_d = SLOT_PEND;
                        tmr_d   = '0;
                    end else begin
                        state_d = SLOT_RRDY;
                    end
                end
                SLOT_DONE: begin
                    if (done_take_i) begin
                        state_d = SLOT_FREE;
                    end else begin
                        state_d = SLOT_DONE;
                    end
                end
                default: state_d = SLOT_FREE;
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= SLOT_FREE;
            tid_q   <= '0;
            st_q    <= DST_ACK;
            tmr_q   <= '0;
            bko_q   <= BKW'(RTY_BASE);
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
            st_q    <= st_d;
            tmr_q   <= tmr_d;
            bko_q   <= bko_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign state_o = state_q;
    assign tid_o   = tid_q;
    assign st_o    = st_q;
    assign hit_o   = hit_s;

endmodule

// File: rtl/fta_tran_tracker.sv
// Transaction-ID tracker: hands out unique tranids, follows each through
// response/retry/timeout, and reports one completion per cycle.
module fta_tran_tracker
    import rf80386_pkg::*;
#(
    parameter int NTAG      = 4,
    parameter int TIDW      = 4,
    parameter int TMO       = 255,
    parameter int RTY_BASE  = 4,
    parameter int RTY_MAX   = 64,
    parameter int RTY_LIMIT = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    fta_tran_tracker_if.slave         bus,
    input  logic                      flush_i,
    output logic                      full_o,
    output logic                      busy_o,
    output logic [$clog2(NTAG+1)-1:0] count_o,
    output logic                      stray_o
);
    localparam int CW = $clog2(NTAG + 1);

    slot_state_e     state_s [NTAG];
    logic [TIDW-1:0] tid_s   [NTAG];
    logic [1:0]      st_s    [NTAG];
    logic [NTAG-1:0] hit_s, free_v_s, rrdy_v_s, done_v_s;
    logic [NTAG-1:0] free_oh_s, rrdy_oh_s, done_oh_s;
    logic [NTAG-1:0] grant_s, take_s, dtake_s;
    logic            held_s, gnt_s, retry_v_s, done_v_s1;
    logic [TIDW-1:0] retry_tid_s, done_tid_s;
    logic [1:0]      done_st_s;
    logic [CW-1:0]   cnt_s;
    logic [TIDW-1:0] cand_q, cand_d;
    logic            stray_q, stray_d;

    function automatic logic [TIDW-1:0] next_tid(input logic [TIDW-1:0] t);
        return (t == {TIDW{1'b1}}) ? TIDW'(1) : t + TIDW'(1);
    endfunction

    for (genvar g = 0; g < NTAG; g++) begin : g_slot
        fta_tran_slot #(
            .TIDW(TIDW), .TMO(TMO), .RTY_BASE(RTY_BASE), .RTY_MAX(RTY_MAX), .RTY_LIMIT(RTY_LIMIT)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .flush_i      (flush_i),
            .grant_i      (grant_s[g]),
            .tid_i        (cand_q),
            .resp_v_i     (bus.resp_v_i),
            .resp_tid_i   (bus.resp_tid_i),
            .resp_ack_i   (bus.resp_ack_i),
            .resp_rty_i   (bus.resp_rty_i),
            .resp_err_i   (bus.resp_err_i),
            .retry_take_i (take_s[g]),
            .done_take_i  (dtake_s[g]),
            .state_o      (state_s[g]),
            .tid_o        (tid_s[g]),
            .st_o         (st_s[g]),
            .hit_o        (hit_s[g])
        );
    end

    // Arbitration: lowest-index pick via isolate-lowest-set-bit on each vector.
    always_comb begin
        held_s = 1'b0;
        cnt_s  = '0;
        for (int i = 0; i < NTAG; i++) begin
            free_v_s[i] = (state_s[i] == SLOT_FREE);
            rrdy_v_s[i] = (state_s[i] == SLOT_RRDY);
            done_v_s[i] = (state_s[i] == SLOT_DONE);
            held_s      = held_s | (!free_v_s[i] && (tid_s[i] == cand_q));
            cnt_s       = cnt_s + (free_v_s[i] ? CW'(0) : CW'(1));
        end
        free_oh_s = free_v_s & (~free_v_s + NTAG'(1));
        rrdy_oh_s = rrdy_v_s & (~rrdy_v_s + NTAG'(1));
        done_oh_s = done_v_s & (~done_v_s + NTAG'(1));

        gnt_s     = rst_i && bus.alloc_req_i && !flush_i && (|free_v_s) && !held_s;
        retry_v_s = !flush_i && (|rrdy_v_s);
        done_v_s1 = !flush_i && (|done_v_s);
        grant_s   = gnt_s ? free_oh_s : '0;
        take_s    = (retry_v_s && bus.retry_take_i) ? rrdy_oh_s : '0;
        dtake_s   = done_v_s1 ? done_oh_s : '0;

        retry_tid_s = '0;
        done_tid_s  = '0;
        done_st_s   = 2'd0;
        for (int i = 0; i < NTAG; i++) begin
            retry_tid_s = retry_tid_s | ({TIDW{take_s[i] | (retry_v_s & rrdy_oh_s[i])}} & tid_s[i]);
            done_tid_s  = done_tid_s  | ({TIDW{dtake_s[i]}} & tid_s[i]);
            done_st_s   = done_st_s   | ({2{dtake_s[i]}} & st_s[i]);
        end

        cand_d  = (bus.alloc_req_i && !flush_i) ? next_tid(cand_q) : cand_q;
        stray_d = bus.resp_v_i && !(|hit_s);
    end

    // Candidate tranid and stray-response pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cand_q  <= TIDW'(1);
            stray_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            stray_q <= stray_d;
        end
    end

    assign bus.alloc_gnt_o = gnt_s;
    assign bus.alloc_tid_o = gnt_s ? cand_q : '0;
    assign bus.retry_v_o   = retry_v_s;
    assign bus.retry_tid_o = retry_tid_s;
    assign bus.done_v_o    = done_v_s1;
    assign bus.done_tid_o  = done_tid_s;
    assign bus.done_st_o   = done_st_s;
    assign count_o         = cnt_s;
    assign full_o          = (cnt_s == CW'(NTAG));
    assign busy_o          = (cnt_s != CW'(0));
    assign stray_o         = stray_q;

endmodule

// File: tb/tb_fta_tran_tracker.sv
// Directed bench for fta_tran_tracker: allocation, stray, retry backoff,
// timeout, completion ordering, flush, tid wrap and reset abandonment.
module tb_fta_tran_tracker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       full, busy, stray;
    logic [2:0] count;
    int         n_assert = 0;
    int         n_fail   = 0;

    fta_tran_tracker_if #(.TIDW(4)) bus ();

    fta_tran_tracker #(
        .NTAG(4), .TIDW(4), .TMO(255), .RTY_BASE(4), .RTY_MAX(64), .RTY_LIMIT(8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus),
        .flush_i (flush),
        .full_o  (full),
        .busy_o  (busy),
        .count_o (count),
        .stray_o (stray)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resp(input logic [3:0] t, input logic a, input logic r, input logic e);
        bus.resp_v_i   = 1'b1;
        bus.resp_tid_i = t;
        bus.resp_ack_i = a;
        bus.resp_rty_i = r;
        bus.resp_err_i = e;
    endtask

    task automatic idle();
        bus.resp_v_i     = 1'b0;
        bus.resp_tid_i   = 4'd0;
        bus.resp_ack_i   = 1'b0;
        bus.resp_rty_i   = 1'b0;
        bus.resp_err_i   = 1'b0;
        bus.retry_take_i = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        idle();
        bus.alloc_req_i = 1'b1;
        repeat (2) cyc();
        #1;
        chk("rst_gnt", bus.alloc_gnt_o, 1'b0);
        chk("rst_atid", bus.alloc_tid_o, 4'd0);
        chk("rst_count", count, 3'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", bus.done_v_o, 1'b0);
        chk("rst_retry", bus.retry_v_o, 1'b0);
        chk("rst_stray", stray, 1'b0);

        // Five request cycles: tids 1..4 then full
        cyc(); rst_n = 1'b1; #1;
        chk("alloc_gnt1", bus.alloc_gnt_o, 1'b1);
        chk("alloc_tid1", bus.alloc_tid_o, 4'd1);
        for (int k = 2; k <= 4; k++) begin
            cyc(); #1;
            chk("alloc_gnt", bus.alloc_gnt_o, 1'b1);
            chk("alloc_tid", bus.alloc_tid_o, k);
        end
        cyc(); #1;
        chk("full_gnt", bus.alloc_gnt_o, 1'b0);
        chk("full_flag", full, 1'b1);
        chk("full_count", count, 3'd4);
        chk("full_busy", busy, 1'b1);

        // C6: stray response tid 9
        cyc(); bus.alloc_req_i = 1'b0; resp(4'd9, 1'b1, 1'b0, 1'b0); #1;
        chk("stray_early", stray, 1'b0);
        cyc(); idle(); #1;
        chk("stray_pulse", stray, 1'b1);
        chk("stray_count", count, 3'd4);
        // C8: retry tid 2
        cyc(); resp(4'd2, 1'b0, 1'b1, 1'b0); #1;
        chk("stray_once", stray, 1'b0);
        cyc(); idle(); #1;
        chk("rwait_c9", bus.retry_v_o, 1'b0);
        chk("rwait_count", count, 3'd4);
        repeat (3) cyc(); #1;
        chk("rwait_c12", bus.retry_v_o, 1'b0);
        cyc(); #1;
        chk("retry1_v", bus.retry_v_o, 1'b1);
        chk("retry1_tid", bus.retry_tid_o, 4'd2);
        bus.retry_take_i = 1'b1;
        // C14: second retry, backoff 8
        cyc(); idle(); #1;
        chk("retry1_taken", bus.retry_v_o, 1'b0);
        resp(4'd2, 1'b0, 1'b1, 1'b0);
        cyc(); idle();
        repeat (7) cyc(); #1;
        chk("rwait8_c22", bus.retry_v_o, 1'b0);
        cyc(); #1;
        chk("retry2_v", bus.retry_v_o, 1'b1);
        chk("retry2_tid", bus.retry_tid_o, 4'd2);
        bus.retry_take_i = 1'b1;
        // C24: ack tid 2
        cyc(); idle(); resp(4'd2, 1'b1, 1'b0, 1'b0);
        cyc(); idle(); #1;
        chk("ack_done_v", bus.done_v_o, 1'b1);
        chk("ack_done_tid", bus.done_tid_o, 4'd2);
        chk("ack_done_st", bus.done_st_o, 2'd0);
        chk("ack_count", count, 3'd4);
        // C26: all flags set on tid 4 -> err wins
        cyc(); resp(4'd4, 1'b1, 1'b1, 1'b1); #1;
        chk("freed_count", count, 3'd3);
        chk("no_done", bus.done_v_o, 1'b0);
        cyc(); idle(); #1;
        chk("err_done_tid", bus.done_tid_o, 4'd4);
        chk("err_done_st", bus.done_st_o, 2'd1);
        // C28: retry tid 1 to restart its timer
        cyc(); resp(4'd1, 1'b0, 1'b1, 1'b0); #1;
        chk("two_left", count, 3'd2);
        cyc(); idle();
        repeat (3) cyc(); #1;
        chk("rwait_s0", bus.retry_v_o, 1'b0);
        cyc(); #1;
        chk("retry_s0_tid", bus.retry_tid_o, 4'd1);
        bus.retry_take_i = 1'b1;
        cyc(); idle();
        // C257: tid 3 one cycle short of timing out
        repeat (223) cyc(); #1;
        chk("pre_tmo", bus.done_v_o, 1'b0);
        chk("pre_tmo_count", count, 3'd2);
        // C258: ack tid 1 while tid 3 times out
        cyc(); resp(4'd1, 1'b1, 1'b0, 1'b0); #1;
        chk("tmo_edge_done", bus.done_v_o, 1'b0);
        cyc(); idle(); #1;
        chk("order_first_tid", bus.done_tid_o, 4'd1);
        chk("order_first_st", bus.done_st_o, 2'd0);
        chk("order_first_cnt", count, 3'd2);
        cyc(); #1;
        chk("tmo_done_v", bus.done_v_o, 1'b1);
        chk("tmo_done_tid", bus.done_tid_o, 4'd3);
        chk("tmo_done_st", bus.done_st_o, 2'd2);
        chk("tmo_count", count, 3'd1);
        cyc(); #1;
        chk("empty_done", bus.done_v_o, 1'b0);
        chk("empty_count", count, 3'd0);
        chk("empty_busy", busy, 1'b0);

        // Flush: candidate held, grant and done suppressed
        cyc(); bus.alloc_req_i = 1'b1; #1;
        chk("pre_flush_tid", bus.alloc_tid_o, 4'd6);
        cyc(); flush = 1'b1; #1;
        chk("flush_gnt", bus.alloc_gnt_o, 1'b0);
        chk("flush_atid", bus.alloc_tid_o, 4'd0);
        cyc(); flush = 1'b0; #1;
        chk("post_flush_cnt", count, 3'd0);
        chk("post_flush_tid", bus.alloc_tid_o, 4'd7);
        cyc(); bus.alloc_req_i = 1'b0; resp(4'd7, 1'b1, 1'b0, 1'b0);
        cyc(); idle(); flush = 1'b1; #1;
        chk("flush_done_v", bus.done_v_o, 1'b0);
        chk("flush_done_tid", bus.done_tid_o, 4'd0);
        cyc(); flush = 1'b0; #1;
        chk("flush_freed", count, 3'd0);
        chk("flush_no_done", bus.done_v_o, 1'b0);

        // Wrap: fill tids 1..4, spin candidate to 15 while full
        cyc(); rst_n = 1'b0; #1;
        chk("rst2_count", count, 3'd0);
        cyc(); rst_n = 1'b1; bus.alloc_req_i = 1'b1; #1;
        chk("rst2_tid1", bus.alloc_tid_o, 4'd1);
        repeat (14) cyc(); #1;
        chk("spin15_gnt", bus.alloc_gnt_o, 1'b0);
        cyc(); bus.alloc_req_i = 1'b0; resp(4'd2, 1'b1, 1'b0, 1'b0);
        cyc(); idle(); #1;
        chk("wrap_free_tid", bus.done_tid_o, 4'd2);
        cyc(); bus.alloc_req_i = 1'b1; #1;
        chk("wrap_count", count, 3'd3);
        chk("wrap_full", full, 1'b0);
        chk("wrap_skip_gnt", bus.alloc_gnt_o, 1'b0);
        chk("wrap_skip_tid", bus.alloc_tid_o, 4'd0);
        cyc(); #1;
        chk("wrap_gnt", bus.alloc_gnt_o, 1'b1);
        chk("wrap_tid2", bus.alloc_tid_o, 4'd2);
        cyc(); bus.alloc_req_i = 1'b0; resp(4'd3, 1'b1, 1'b0, 1'b0);
        cyc(); idle(); #1;
        chk("wrap_done3", bus.done_tid_o, 4'd3);
        cyc(); #1;
        chk("pre_rst_cnt", count, 3'd3);
        #1 rst_n = 1'b0; bus.alloc_req_i = 1'b1; #1;
        chk("midrst_count", count, 3'd0);
        chk("midrst_done", bus.done_v_o, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_gnt", bus.alloc_gnt_o, 1'b0);
        cyc(); rst_n = 1'b1; bus.alloc_req_i = 1'b0; #1;
        chk("postrst_count", count, 3'd0);
        chk("postrst_done", bus.done_v_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
